// File: rtl/idma_desc64_reg_submitter.sv
// Register-bus initiator: writes descriptor pointers into the desc64 frontend.
// Optional status polling before each write: IDMA_DESC64_SUBMIT_POLL_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a pointer; accepts when below the inflight limit
// POLL     | reading the status register until the frontend is not busy
// WRITE    | writing the held pointer to the descriptor-address register
// ERROR    | bus error seen; holds the pointer until error_clear_i
module idma_desc64_reg_submitter #(
  parameter int unsigned          AddrWidth      = 64,
  parameter int unsigned          DataWidth      = 64,
  parameter logic [AddrWidth-1:0] RegBaseAddr    = '0,
  parameter logic [AddrWidth-1:0] DescAddrOffset = 'h0,
  parameter logic [AddrWidth-1:0] StatusOffset   = 'h8,
  parameter int unsigned          MaxInflight    = 8,
  parameter type reg_req_t = struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   write;
    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] wstrb;
    logic                   valid;
  },
  parameter type reg_rsp_t = struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 error;
    logic                 ready;
  },
  localparam int unsigned CntW = $clog2(MaxInflight + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] desc_addr_i,
  input  logic                 desc_valid_i,
  output logic                 desc_ready_o,
  input  logic                 irq_i,
  output reg_req_t             reg_req_o,
  input  reg_rsp_t             reg_rsp_i,
  output logic [CntW-1:0]      inflight_o,
  output logic                 idle_o,
  output logic                 error_o,
  input  logic                 error_clear_i
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
`ifdef IDMA_DESC64_SUBMIT_POLL_EN
  localparam logic [1:0] ST_POLL  = 2'd1;
`endif
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  localparam logic [CntW-1:0]      MaxCnt        = CntW'(MaxInflight);
  localparam logic [AddrWidth-1:0] DescRegAddr   = RegBaseAddr + DescAddrOffset;
  localparam logic [AddrWidth-1:0] StatusRegAddr = RegBaseAddr + StatusOffset;

  logic [1:0]           state_q;
  logic [AddrWidth-1:0] ptr_q;
  logic [CntW-1:0]      cnt_q;
  logic                 err_q;
  logic                 accept;
  logic                 wr_ok;
  logic                 cnt_dec;

`ifdef IDMA_DESC64_SUBMIT_POLL_EN
  logic poll_gap_q;
  logic err_in_poll_q;
`endif

  // Gated with rst_i so the stream never sees ready while reset is held.
  assign desc_ready_o = (state_q == ST_IDLE) && (cnt_q < MaxCnt) && !err_q && !rst_i;
  assign accept       = desc_valid_i && desc_ready_o;
  assign wr_ok        = (state_q == ST_WRITE) && reg_rsp_i.ready && !reg_rsp_i.error;
  assign cnt_dec      = irq_i && (cnt_q != '0);

  assign inflight_o = cnt_q;
  assign error_o    = err_q;
  assign idle_o     = (state_q == ST_IDLE) && (cnt_q == '0);

  always_comb begin
    reg_req_o = '0;
    if (state_q == ST_WRITE) begin
      reg_req_o.valid = 1'b1;
      reg_req_o.write = 1'b1;
      reg_req_o.addr  = DescRegAddr;
      reg_req_o.wdata = DataWidth'(ptr_q);
      reg_req_o.wstrb = '1;
    end
`ifdef IDMA_DESC64_SUBMIT_POLL_EN
    if ((state_q == ST_POLL) && !poll_gap_q) begin
      reg_req_o.valid = 1'b1;
      reg_req_o.addr  = StatusRegAddr;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case ({wr_ok, cnt_dec})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            ptr_q <= desc_addr_i;
`ifdef IDMA_DESC64_SUBMIT_POLL_EN
            state_q <= ST_POLL;
`else
            state_q <= ST_WRITE;
`endif
          end
        end
`ifdef IDMA_DESC64_SUBMIT_POLL_EN
        ST_POLL: begin
          if (!poll_gap_q && reg_rsp_i.ready) begin
            if (reg_rsp_i.error) begin
              state_q <= ST_ERROR;
              err_q   <= 1'b1;
            end else if (!reg_rsp_i.rdata[0]) begin
              state_q <= ST_WRITE;
            end
          end
        end
`endif
        ST_WRITE: begin
          if (reg_rsp_i.ready) begin
            if (reg_rsp_i.error) begin
              state_q <= ST_ERROR;
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_ERROR: begin
          if (error_clear_i) begin
            err_q <= 1'b0;
`ifdef IDMA_DESC64_SUBMIT_POLL_EN
            state_q <= err_in_poll_q ? ST_POLL : ST_WRITE;
`else
            state_q <= ST_WRITE;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef IDMA_DESC64_SUBMIT_POLL_EN
  // A busy status read is followed by one cycle with valid low before re-reading.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      poll_gap_q    <= 1'b0;
      err_in_poll_q <= 1'b0;
    end else begin
      if (state_q == ST_POLL) begin
        if (poll_gap_q) begin
          poll_gap_q <= 1'b0;
        end else if (reg_rsp_i.ready && !reg_rsp_i.error && reg_rsp_i.rdata[0]) begin
          poll_gap_q <= 1'b1;
        end
      end else begin
        poll_gap_q <= 1'b0;
      end
      if ((state_q == ST_POLL) && !poll_gap_q && reg_rsp_i.ready && reg_rsp_i.error) begin
        err_in_poll_q <= 1'b1;
      end else if ((state_q == ST_WRITE) && reg_rsp_i.ready && reg_rsp_i.error) begin
        err_in_poll_q <= 1'b0;
      end
    end
  end
`endif

  logic unused_rsp;
  assign unused_rsp = ^{reg_rsp_i.rdata, StatusRegAddr};

endmodule

// File: tb/tb_idma_desc64_reg_submitter.sv
// Directed bench for idma_desc64_reg_submitter (MaxInflight = 2).
// With IDMA_DESC64_SUBMIT_POLL_EN defined only the reset and poll scenarios run.
module tb_idma_desc64_reg_submitter;

  typedef struct packed {
    logic [63:0] addr;
    logic        write;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        valid;
  } req_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        error;
    logic        ready;
  } rsp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] desc_addr_i;
  logic        desc_valid_i;
  logic        desc_ready_o;
  logic        irq_i;
  req_t        reg_req_o;
  rsp_t        reg_rsp_i;
  logic [1:0]  inflight_o;
  logic        idle_o;
  logic        error_o;
  logic        error_clear_i;

  int n_checks = 0;
  int n_pass   = 0;

  int          cyc = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          wr_cyc = 0;
  int          rd_cyc [8];
  logic [63:0] last_waddr, last_wdata, last_raddr;
  logic [7:0]  last_wstrb, last_rstrb;

  idma_desc64_reg_submitter #(
    .AddrWidth   (64),
    .DataWidth   (64),
    .MaxInflight (2),
    .reg_req_t   (req_t),
    .reg_rsp_t   (rsp_t)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .desc_addr_i   (desc_addr_i),
    .desc_valid_i  (desc_valid_i),
    .desc_ready_o  (desc_ready_o),
    .irq_i         (irq_i),
    .reg_req_o     (reg_req_o),
    .reg_rsp_i     (reg_rsp_i),
    .inflight_o    (inflight_o),
    .idle_o        (idle_o),
    .error_o       (error_o),
    .error_clear_i (error_clear_i)
  );

  always #5 clk_i = ~clk_i;

  // Bus monitor: logs every completed beat.
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (!rst_i && reg_req_o.valid && reg_rsp_i.ready) begin
      if (reg_req_o.write) begin
        wr_cnt     <= wr_cnt + 1;
        wr_cyc     <= cyc;
        last_waddr <= reg_req_o.addr;
        last_wdata <= reg_req_o.wdata;
        last_wstrb <= reg_req_o.wstrb;
      end else begin
        rd_cnt     <= rd_cnt + 1;
        if (rd_cnt < 8) rd_cyc[rd_cnt] <= cyc;
        last_raddr <= reg_req_o.addr;
        last_rstrb <= reg_req_o.wstrb;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_irq();
    irq_i = 1'b1;
    step();
    irq_i = 1'b0;
  endtask

  task automatic submit(input logic [63:0] p);
    desc_addr_i  = p;
    desc_valid_i = 1'b1;
    for (int i = 0; i < 20 && !desc_ready_o; i++) step();
    if (!desc_ready_o) begin
      n_checks++;
      $display("FAIL submit_timeout: desc_ready_o still %b after 20 cycles, want 1", desc_ready_o);
    end
    step();
    desc_valid_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    desc_addr_i = '0; desc_valid_i = 1'b0; irq_i = 1'b0; error_clear_i = 1'b0;
    reg_rsp_i = '0;
    #2;
    n_checks++; if (desc_ready_o !== 1'b0) $display("FAIL rst_ready: got %b want 0", desc_ready_o); else n_pass++;
    n_checks++; if (reg_req_o !== '0) $display("FAIL rst_req: got %h want 0", reg_req_o); else n_pass++;
    n_checks++; if (inflight_o !== 2'd0) $display("FAIL rst_inflight: got %0d want 0", inflight_o); else n_pass++;
    n_checks++; if (error_o !== 1'b0) $display("FAIL rst_error: got %b want 0", error_o); else n_pass++;
    step(); step();
    rst_i = 1'b0;
    step();
    n_checks++; if (idle_o !== 1'b1) $display("FAIL rst_idle: got %b want 1", idle_o); else n_pass++;
    n_checks++; if (desc_ready_o !== 1'b1) $display("FAIL rst_ready_after: got %b want 1", desc_ready_o); else n_pass++;
  endtask

  task automatic test_single_submit();
    int w0;
    w0 = wr_cnt;
    reg_rsp_i.ready = 1'b1;
    desc_addr_i  = 64'h8000_1000;
    desc_valid_i = 1'b1;
    n_checks++; if (reg_req_o.valid !== 1'b0) $display("FAIL single_valid_pre: got %b want 0", reg_req_o.valid); else n_pass++;
    step();
    desc_valid_i = 1'b0;
    n_checks++; if (reg_req_o.valid !== 1'b1 || reg_req_o.write !== 1'b1) $display("FAIL single_req: valid %b write %b want 1 1", reg_req_o.valid, reg_req_o.write); else n_pass++;
    n_checks++; if (reg_req_o.addr !== 64'h0) $display("FAIL single_addr: got %h want 0", reg_req_o.addr); else n_pass++;
    n_checks++; if (reg_req_o.wdata !== 64'h8000_1000) $display("FAIL single_wdata: got %h want 80001000", reg_req_o.wdata); else n_pass++;
    n_checks++; if (reg_req_o.wstrb !== 8'hFF) $display("FAIL single_wstrb: got %h want ff", reg_req_o.wstrb); else n_pass++;
    step();
    n_checks++; if (reg_req_o.valid !== 1'b0) $display("FAIL single_valid_post: got %b want 0", reg_req_o.valid); else n_pass++;
    n_checks++; if (inflight_o !== 2'd1) $display("FAIL single_inflight: got %0d want 1", inflight_o); else n_pass++;
    n_checks++; if (wr_cnt - w0 !== 1) $display("FAIL single_wr_count: got %0d want 1", wr_cnt - w0); else n_pass++;
    pulse_irq();
    n_checks++; if (inflight_o !== 2'd0 || idle_o !== 1'b1) $display("FAIL single_irq: inflight %0d idle %b want 0 1", inflight_o, idle_o); else n_pass++;
  endtask

  task automatic test_backpressure();
    int w0;
    w0 = wr_cnt;
    reg_rsp_i.ready = 1'b0;
    desc_addr_i  = 64'h1234_5678_9ABC_DEF0;
    desc_valid_i = 1'b1;
    step();
    desc_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (reg_req_o.valid !== 1'b1 || reg_req_o.addr !== 64'h0 || reg_req_o.wdata !== 64'h1234_5678_9ABC_DEF0)
        $display("FAIL bp_stable_%0d: valid %b addr %h wdata %h want 1 0 123456789abcdef0", i, reg_req_o.valid, reg_req_o.addr, reg_req_o.wdata);
      else n_pass++;
      if (i < 4) step();
    end
    reg_rsp_i.ready = 1'b1;
    step();
    n_checks++; if (wr_cnt - w0 !== 1) $display("FAIL bp_one_transfer: got %0d want 1", wr_cnt - w0); else n_pass++;
    n_checks++; if (reg_req_o.valid !== 1'b0 || inflight_o !== 2'd1) $display("FAIL bp_after: valid %b inflight %0d want 0 1", reg_req_o.valid, inflight_o); else n_pass++;
    pulse_irq();
  endtask

  task automatic test_throttle();
    int w0;
    w0 = wr_cnt;
    reg_rsp_i.ready = 1'b1;
    submit(64'hA000_0000);
    submit(64'hB000_0000);
    desc_addr_i  = 64'hC000_0000;
    desc_valid_i = 1'b1;
    step(); step(); step();
    n_checks++; if (desc_ready_o !== 1'b0) $display("FAIL thr_ready: got %b want 0", desc_ready_o); else n_pass++;
    n_checks++; if (inflight_o !== 2'd2) $display("FAIL thr_inflight: got %0d want 2", inflight_o); else n_pass++;
    n_checks++; if (wr_cnt - w0 !== 2) $display("FAIL thr_writes: got %0d want 2", wr_cnt - w0); else n_pass++;
    pulse_irq();
    n_checks++; if (desc_ready_o !== 1'b1 || inflight_o !== 2'd1) $display("FAIL thr_release: ready %b inflight %0d want 1 1", desc_ready_o, inflight_o); else n_pass++;
    step();
    desc_valid_i = 1'b0;
    step();
    n_checks++; if (wr_cnt - w0 !== 3 || last_wdata !== 64'hC000_0000) $display("FAIL thr_third: writes %0d wdata %h want 3 c0000000", wr_cnt - w0, last_wdata); else n_pass++;
    n_checks++; if (inflight_o !== 2'd2) $display("FAIL thr_inflight2: got %0d want 2", inflight_o); else n_pass++;
    pulse_irq();
    pulse_irq();
  endtask

  task automatic test_simultaneous();
    reg_rsp_i.ready = 1'b1;
    submit(64'h0000_0000_0000_1111);
    n_checks++; if (inflight_o !== 2'd1) $display("FAIL sim_pre: got %0d want 1", inflight_o); else n_pass++;
    desc_addr_i  = 64'h2222;
    desc_valid_i = 1'b1;
    step();
    desc_valid_i = 1'b0;
    irq_i = 1'b1;
    step();
    irq_i = 1'b0;
    n_checks++; if (inflight_o !== 2'd1) $display("FAIL sim_irq_wr: got %0d want 1", inflight_o); else n_pass++;
    pulse_irq();
    n_checks++; if (inflight_o !== 2'd0) $display("FAIL sim_to_zero: got %0d want 0", inflight_o); else n_pass++;
    pulse_irq();
    n_checks++; if (inflight_o !== 2'd0 || idle_o !== 1'b1) $display("FAIL sim_irq_at_zero: inflight %0d idle %b want 0 1", inflight_o, idle_o); else n_pass++;
  endtask

  task automatic test_error_retry();
    int w0;
    w0 = wr_cnt;
    reg_rsp_i.ready = 1'b1;
    reg_rsp_i.error = 1'b1;
    desc_addr_i  = 64'hDEAD_0000;
    desc_valid_i = 1'b1;
    step();
    desc_valid_i = 1'b0;
    step();
    n_checks++; if (error_o !== 1'b1 || desc_ready_o !== 1'b0) $display("FAIL err_flag: error %b ready %b want 1 0", error_o, desc_ready_o); else n_pass++;
    n_checks++; if (reg_req_o.valid !== 1'b0 || inflight_o !== 2'd0) $display("FAIL err_hold: valid %b inflight %0d want 0 0", reg_req_o.valid, inflight_o); else n_pass++;
    step();
    n_checks++; if (error_o !== 1'b1) $display("FAIL err_sticky: got %b want 1", error_o); else n_pass++;
    reg_rsp_i.error = 1'b0;
    error_clear_i   = 1'b1;
    step();
    error_clear_i   = 1'b0;
    n_checks++; if (reg_req_o.valid !== 1'b1 || reg_req_o.wdata !== 64'hDEAD_0000 || error_o !== 1'b0) $display("FAIL err_reissue: valid %b wdata %h error %b want 1 dead0000 0", reg_req_o.valid, reg_req_o.wdata, error_o); else n_pass++;
    step();
    n_checks++; if (inflight_o !== 2'd1 || wr_cnt - w0 !== 2) $display("FAIL err_done: inflight %0d beats %0d want 1 2", inflight_o, wr_cnt - w0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    reg_rsp_i.ready = 1'b0;
    desc_addr_i  = 64'h5555;
    desc_valid_i = 1'b1;
    step();
    desc_valid_i = 1'b0;
    n_checks++; if (reg_req_o.valid !== 1'b1) $display("FAIL mid_valid: got %b want 1", reg_req_o.valid); else n_pass++;
    rst_i = 1'b1;
    #1;
    n_checks++; if (reg_req_o.valid !== 1'b0 || inflight_o !== 2'd0) $display("FAIL mid_async: valid %b inflight %0d want 0 0", reg_req_o.valid, inflight_o); else n_pass++;
    step();
    rst_i = 1'b0;
    step();
    n_checks++; if (idle_o !== 1'b1 || reg_req_o.valid !== 1'b0) $display("FAIL mid_recover: idle %b valid %b want 1 0", idle_o, reg_req_o.valid); else n_pass++;
  endtask

  task automatic test_poll();
    int w0, r0;
    w0 = wr_cnt;
    r0 = rd_cnt;
    reg_rsp_i.ready = 1'b1;
    desc_addr_i  = 64'h7777_0000;
    desc_valid_i = 1'b1;
    step();
    desc_valid_i = 1'b0;
    for (int i = 0; i < 40 && wr_cnt == w0; i++) begin
      reg_rsp_i.rdata = {63'b0, (rd_cnt - r0) < 2};
      step();
    end
    n_checks++; if (wr_cnt - w0 !== 1) $display("FAIL poll_write_count: got %0d want 1", wr_cnt - w0); else n_pass++;
    n_checks++; if (rd_cnt - r0 !== 3) $display("FAIL poll_read_count: got %0d want 3", rd_cnt - r0); else n_pass++;
    n_checks++; if (rd_cyc[1] - rd_cyc[0] !== 2 || rd_cyc[2] - rd_cyc[1] !== 2) $display("FAIL poll_spacing: got %0d %0d want 2 2", rd_cyc[1] - rd_cyc[0], rd_cyc[2] - rd_cyc[1]); else n_pass++;
    n_checks++; if (wr_cyc - rd_cyc[2] !== 1) $display("FAIL poll_write_gap: got %0d want 1", wr_cyc - rd_cyc[2]); else n_pass++;
    n_checks++; if (last_raddr !== 64'h8 || last_rstrb !== 8'h00) $display("FAIL poll_read_fields: addr %h strb %h want 8 00", last_raddr, last_rstrb); else n_pass++;
    n_checks++; if (last_waddr !== 64'h0 || last_wdata !== 64'h7777_0000) $display("FAIL poll_write_fields: addr %h wdata %h want 0 77770000", last_waddr, last_wdata); else n_pass++;
    step();
    n_checks++; if (inflight_o !== 2'd1 || wr_cnt - w0 !== 1) $display("FAIL poll_after: inflight %0d writes %0d want 1 1", inflight_o, wr_cnt - w0); else n_pass++;
  endtask

  initial begin
    test_reset();
`ifdef IDMA_DESC64_SUBMIT_POLL_EN
    test_poll();
`else
    test_single_submit();
    test_backpressure();
    test_throttle();
    test_simultaneous();
    test_error_retry();
    test_reset_mid();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
